store_buffer: RTL and testbench

Post-commit store buffer between the memory stage and the data cache. Retired stores are queued in a small FIFO, so the pipeline does not wait for each store's cache write. The buffer drains to the data cache one entry at a time. Younger loads are served by store-to-load forwarding, or stalled when forwarding is not possible. A fence request blocks new stores until the buffer is empty, for TLB writes and privilege changes.

---
 rtl/sb_pkg.sv | 15 +
 rtl/sb_fwd_match.sv | 53 +++++
 rtl/store_buffer.sv | 101 ++++++++++
 tb/tb_store_buffer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared types for the post-commit store buffer: entry layout, control FSM
// states and the word-offset width used for overlap checks.
package sb_pkg;
  localparam int SB_OFF_W  = 2;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic                 is_byte;
  } sb_entry_t;

  typedef enum logic {RUN, FENCE} sb_state_t;
endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding: scans valid entries youngest first and lets the
// first entry that decides (hit or stall) set the outcome.
module sb_fwd_match
  import sb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] ent_i,
  input  logic [PTR_W-1:0]      head_i,
  input  logic [PTR_W:0]        count_i,
  input  logic                  ld_valid_i,
  input  logic [SB_ADDR_W-1:0]  ld_addr_i,
  input  logic                  ld_byte_i,
  output logic                  hit_o,
  output logic                  stall_o,
  output logic [SB_DATA_W-1:0]  data_o
);
  logic             done;
  logic [PTR_W-1:0] idx;
  sb_entry_t        e;

  always_comb begin
    hit_o   = 1'b0;
    stall_o = 1'b0;
    data_o  = '0;
    idx     = '0;
    e       = '0;
    done    = !ld_valid_i;
    for (int k = 0; k < DEPTH; k++) begin
      // k = 0 is the youngest entry (tail - 1)
      idx = head_i + PTR_W'(count_i) - PTR_W'(k) - PTR_W'(1);
      e   = ent_i[idx];
      if (!done && (k < int'(count_i)) &&
          (e.addr[SB_ADDR_W-1:SB_OFF_W] == ld_addr_i[SB_ADDR_W-1:SB_OFF_W])) begin
        if (!e.is_byte) begin
          hit_o  = 1'b1;
          done   = 1'b1;
          data_o = ld_byte_i ? SB_DATA_W'(e.data[{ld_addr_i[SB_OFF_W-1:0], 3'b000} +: 8])
                             : e.data;
        end else if (!ld_byte_i) begin
          stall_o = 1'b1;
          done    = 1'b1;
        end else if (e.addr[SB_OFF_W-1:0] == ld_addr_i[SB_OFF_W-1:0]) begin
          hit_o  = 1'b1;
          done   = 1'b1;
          data_o = SB_DATA_W'(e.data[7:0]);
        end
        // byte entry, other byte of the same word: fall through to older entries
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: circular FIFO of retired stores draining to the
// data cache, with load forwarding and a fence that waits for empty.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_byte,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic              ld_byte,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_stall,
  output logic              sb_full,
  output logic              sb_empty,
  output logic              drain_req,
  output logic [ADDR_W-1:0] drain_addr,
  output logic [DATA_W-1:0] drain_data,
  output logic              drain_byte,
  input  logic              drain_ack,
  input  logic              fence_req,
  output logic              fence_done
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  sb_state_t             state_q, state_d;
  logic                  enq, deq;
  logic [SB_DATA_W-1:0]  fwd_data_w;

  assign sb_empty   = (count_q == '0);
  assign drain_req  = !sb_empty;
  assign drain_addr = ADDR_W'(mem_q[head_q].addr);
  assign drain_data = DATA_W'(mem_q[head_q].data);
  assign drain_byte = mem_q[head_q].is_byte;

  assign enq     = st_valid && !sb_full;
  assign deq     = drain_ack && drain_req;
  assign head_d  = deq ? head_q + PTR_W'(1) : head_q;
  assign tail_d  = enq ? tail_q + PTR_W'(1) : tail_q;
  assign count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

  always_comb begin
    state_d    = state_q;
    sb_full    = (count_q == CNT_W'(DEPTH));
    fence_done = 1'b0;
    case (state_q)
      RUN:   if (fence_req) state_d = FENCE;
      FENCE: begin
        sb_full = 1'b1;
        if (count_q == '0) begin
          fence_done = 1'b1;
          state_d    = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) mem_q[tail_q] <= '{addr: SB_ADDR_W'(st_addr),
                                  data: SB_DATA_W'(st_data),
                                  is_byte: st_byte};
    end
  end

  sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
    .ent_i      (mem_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .ld_valid_i (ld_valid),
    .ld_addr_i  (SB_ADDR_W'(ld_addr)),
    .ld_byte_i  (ld_byte),
    .hit_o      (fwd_hit),
    .stall_o    (fwd_stall),
    .data_o     (fwd_data_w)
  );
  assign fwd_data = DATA_W'(fwd_data_w);
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: full/ignore, forwarding cases, wrap with
// simultaneous enqueue+drain, fences and reset.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, st_byte, ld_valid, ld_byte, drain_ack, fence_req;
  logic [31:0] st_addr, st_data, ld_addr;
  logic        fwd_hit, fwd_stall, sb_full, sb_empty, drain_req, drain_byte, fence_done;
  logic [31:0] fwd_data, drain_addr, drain_data;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_byte(st_byte),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
    .sb_full(sb_full), .sb_empty(sb_empty),
    .drain_req(drain_req), .drain_addr(drain_addr), .drain_data(drain_data),
    .drain_byte(drain_byte), .drain_ack(drain_ack),
    .fence_req(fence_req), .fence_done(fence_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b);
    st_valid = 1'b1; st_addr = a; st_data = d; st_byte = b;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic b);
    ld_valid = 1'b1; ld_addr = a; ld_byte = b;
    #1;
  endtask

  task automatic pop();
    drain_ack = 1'b1;
    tick();
    drain_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    st_valid = 0; st_byte = 0; st_addr = 0; st_data = 0;
    ld_valid = 0; ld_byte = 0; ld_addr = 0;
    drain_ack = 0; fence_req = 0;
    tick(); tick();
    chk("rst_full", 32'(sb_full), 32'd0);
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_dreq", 32'(drain_req), 32'd0);
    chk("rst_fdone", 32'(fence_done), 32'd0);
    chk("rst_hit", 32'(fwd_hit), 32'd0);
    chk("rst_stall", 32'(fwd_stall), 32'd0);
    chk("rst_daddr", drain_addr, 32'd0);
    chk("rst_ddata", drain_data, 32'd0);
    reset = 1'b0;

    // fill to full; fifth store must be dropped
    store(32'h10, 32'h1, 1'b0);
    chk("lat_dreq", 32'(drain_req), 32'd1);
    chk("lat_daddr", drain_addr, 32'h10);
    store(32'h14, 32'h2, 1'b0);
    store(32'h18, 32'h3, 1'b0);
    chk("full_at3", 32'(sb_full), 32'd0);
    store(32'h1C, 32'h4, 1'b0);
    chk("full_at4", 32'(sb_full), 32'd1);
    store(32'h20, 32'h5, 1'b0);
    chk("full_ign", 32'(sb_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("drain_ord", drain_addr, 32'h10 + 32'(4 * k));
      chk("drain_dat", drain_data, 32'(k + 1));
      pop();
    end
    chk("fifth_dropped", 32'(sb_empty), 32'd1);

    // drain_ack with nothing buffered is ignored
    pop();
    chk("ack_empty", 32'(sb_empty), 32'd1);

    // word entry, byte and word loads
    store(32'h100, 32'hAABBCCDD, 1'b0);
    load(32'h102, 1'b1);
    chk("wb_hit", 32'(fwd_hit), 32'd1);
    chk("wb_data", fwd_data, 32'h000000BB);
    load(32'h100, 1'b0);
    chk("ww_data", fwd_data, 32'hAABBCCDD);
    load(32'h104, 1'b0);
    chk("miss_hit", 32'(fwd_hit), 32'd0);
    ld_valid = 1'b0; #1;
    chk("ldv0_hit", 32'(fwd_hit), 32'd0);
    pop();

    // byte entry: word load stalls, other byte misses
    store(32'h104, 32'hFFFFFF11, 1'b1);
    load(32'h104, 1'b0);
    chk("bw_stall", 32'(fwd_stall), 32'd1);
    chk("bw_hit", 32'(fwd_hit), 32'd0);
    load(32'h104, 1'b1);
    chk("bb_data", fwd_data, 32'h11);
    load(32'h105, 1'b1);
    chk("bb_other", {30'd0, fwd_hit, fwd_stall}, 32'd0);
    chk("dbyte", 32'(drain_byte), 32'd1);
    ld_valid = 1'b0;
    pop();
    load(32'h104, 1'b0);
    chk("post_drain", {30'd0, fwd_hit, fwd_stall}, 32'd0);
    ld_valid = 1'b0;

    // byte over word: fall-through to the older word entry
    store(32'h200, 32'h55667788, 1'b0);
    store(32'h201, 32'h00000011, 1'b1);
    load(32'h200, 1'b1);
    chk("ft_b0", fwd_data, 32'h88);
    load(32'h201, 1'b1);
    chk("ft_b1", fwd_data, 32'h11);
    load(32'h203, 1'b1);
    chk("ft_b3", fwd_data, 32'h55);
    load(32'h200, 1'b0);
    chk("ft_wstall", 32'(fwd_stall), 32'd1);
    ld_valid = 1'b0;
    pop(); pop();
    chk("ft_empty", 32'(sb_empty), 32'd1);

    // simultaneous enqueue + drain at count 3, tail wraps
    store(32'h300, 32'hA, 1'b0);
    store(32'h304, 32'hB, 1'b0);
    store(32'h308, 32'hC, 1'b0);
    drain_ack = 1'b1;
    store(32'h30C, 32'hD, 1'b0);
    chk("sim_head1", drain_addr, 32'h304);
    chk("sim_full1", 32'(sb_full), 32'd0);
    store(32'h310, 32'hE, 1'b0);
    drain_ack = 1'b0;
    chk("sim_head2", drain_addr, 32'h308);
    load(32'h310, 1'b0);
    chk("wrap_fwd", fwd_data, 32'hE);
    ld_valid = 1'b0;
    store(32'h314, 32'hF, 1'b0);
    chk("sim_cnt3", 32'(sb_full), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_ord", drain_addr, 32'h308 + 32'(4 * k));
      pop();
    end
    chk("wrap_empty", 32'(sb_empty), 32'd1);

    // fence with two entries, acks three cycles apart
    store(32'h400, 32'h1, 1'b0);
    store(32'h404, 32'h2, 1'b0);
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("fen_full", 32'(sb_full), 32'd1);
    chk("fen_done0", 32'(fence_done), 32'd0);
    pop();
    tick(); tick();
    chk("fen_hold", 32'(sb_full), 32'd1);
    chk("fen_done1", 32'(fence_done), 32'd0);
    pop();
    chk("fen_pulse", 32'(fence_done), 32'd1);
    chk("fen_full2", 32'(sb_full), 32'd1);
    tick();
    chk("fen_done2", 32'(fence_done), 32'd0);
    chk("fen_run", 32'(sb_full), 32'd0);

    // fence while empty; a store during FENCE is dropped
    fence_req = 1'b1;
    tick();
    fence_req = 1'b0;
    chk("efen_pulse", 32'(fence_done), 32'd1);
    store(32'h500, 32'h9, 1'b0);
    chk("efen_drop", 32'(sb_empty), 32'd1);
    chk("efen_done", 32'(fence_done), 32'd0);

    // reset mid-operation loses entries
    store(32'h600, 32'h7, 1'b0);
    chk("pre_rst", 32'(sb_empty), 32'd0);
    reset = 1'b1; #1;
    chk("mid_rst", 32'(sb_empty), 32'd1);
    chk("mid_rst_d", drain_addr, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
